bus8_arbiter_x2: RTL and testbench
==================================

Name: bus8_arbiter_x2

Overview:
- Two-requester arbiter and sequencer for the 8-bit FPGA register bus.
- Sits between two bus masters and the shared bus that fans out to register slaves; the masters are, for example, a UART command decoder and an on-chip sequencer.
- Grants one transaction at a time with round-robin priority, drives a single-cycle bus strobe, and collects read data.
- A read watchdog guarantees every request gets an acknowledge, even if no slave responds.

Parameters:
- ADDR_WIDTH, 8: width of the bus address.
- TIMEOUT_CYCLES, 16: cycles to wait for i_Bus_Rd_DV after a read strobe before aborting; legal range 1..255.

Ports:
- i_Bus_Rst_L  in  1  reset, asynchronous, active-low
- i_Bus_Clk  in  1  clock; all logic on its rising edge
- i_M0_Req  in  1  requester 0 transaction request, level
- i_M0_Wr_Rd_n  in  1  requester 0: 1 = write, 0 = read
- i_M0_Addr  in  ADDR_WIDTH  requester 0 address
- i_M0_Wr_Data  in  8  requester 0 write data
- o_M0_Ack  out  1  one-cycle completion pulse to requester 0
- o_M0_Rd_Data  out  8  read data; valid with o_M0_Ack
- o_M0_Timeout  out  1  high with o_M0_Ack when the read timed out
- i_M1_Req, i_M1_Wr_Rd_n, i_M1_Addr, i_M1_Wr_Data, o_M1_Ack, o_M1_Rd_Data, o_M1_Timeout: same as M0, for requester 1
- o_Bus_CS  out  1  bus strobe, one cycle per transaction
- o_Bus_Wr_Rd_n  out  1  bus direction
- o_Bus_Addr8  out  ADDR_WIDTH  bus address
- o_Bus_Wr_Data  out  8  bus write data
- i_Bus_Rd_Data  in  8  read data from slaves (OR/muxed externally)
- i_Bus_Rd_DV  in  1  read data valid from slaves
- o_Busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (i_Bus_Rst_L low, asynchronous):
  - All outputs go to 0, state goes to IDLE, timeout counter clears.
  - Last-grant register is set to 1, so M0 wins the first contention.
  - An in-flight transaction is dropped with no Ack issued; requesters must re-request after reset.
- Requester contract:
  - Hold Req and the fields stable until Ack.
  - Req still high in the cycle after the Ack cycle means a new transaction.
  - A registered requester that clears Req on sampling Ack therefore gets exactly one transaction.
- All outputs are registered. States: IDLE, ISSUE, WAIT_RD, ACK.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one Req high: grant that requester.
  - Both Req high: grant the requester not granted last.
  - On grant: latch the winner's fields, record the winner as last-grant, go to ISSUE.
- ISSUE (exactly one cycle):
  - o_Bus_CS=1 with the latched Wr_Rd_n, Addr and Wr_Data on the bus.
  - Write: go to ACK.
  - Read: clear the counter, go to WAIT_RD.
  - o_Bus_CS is 0 in every other state. Address and data outputs hold their last value.
- WAIT_RD:
  - i_Bus_Rd_DV=1: capture i_Bus_Rd_Data, go to ACK with timeout=0.
  - Otherwise increment the counter. When the counter reaches TIMEOUT_CYCLES-1 without DV, go to ACK with data=8'hFF and timeout=1.
  - DV in the same cycle as expiry: the data wins, timeout=0.
- ACK (one cycle):
  - o_Mx_Ack=1 for the granted requester only.
  - Its o_Mx_Rd_Data and o_Mx_Timeout are updated in this cycle and hold until its next Ack.
  - Writes leave Rd_Data unchanged and report Timeout=0.
  - Go to IDLE.
- i_Bus_Rd_DV outside WAIT_RD is ignored.
- Latency, with request seen in IDLE at cycle N:
  - CS at N+1.
  - Write Ack at N+2.
  - Read with a slave answering at N+2: Ack at N+3.
  - Read timeout: Ack at N+2+TIMEOUT_CYCLES.
- Minimum spacing between successive strobes is 3 cycles (ISSUE, ACK, IDLE).
- Req changing while the arbiter is not in IDLE has no effect until IDLE.

Decomposition:
- Shared package bus8_pkg:
  - state enum (IDLE, ISSUE, WAIT_RD, ACK)
  - constants BUS_WRITE=1'b1, BUS_READ=1'b0, RD_TIMEOUT_DATA=8'hFF
- Sub-module bus8_rr_arb2: two request inputs, a last-grant register with update enable, one-hot grant output. Reused later for wider arbiters.
- Timeout counter width: $clog2(TIMEOUT_CYCLES+1).

Test Plan:
- M0 write, Addr=8'h01, data=8'hA5, slave idle -> o_Bus_CS one cycle at N+1 with Wr_Rd_n=1, Addr=01, Wr_Data=A5; o_M0_Ack at N+2; o_M1_Ack stays 0.
- M1 read, Addr=8'h00; slave returns DV with data 8'h3C at N+2 -> o_M1_Ack at N+3, o_M1_Rd_Data=3C, o_M1_Timeout=0.
- M0 and M1 Req high together, each held for 3 back-to-back transactions:
  - grants alternate M0, M1, M0, M1, M0, M1
  - CS strobes 3 cycles apart
  - no cycle where both Acks are high
- M0 read with no slave response, TIMEOUT_CYCLES=16 -> o_M0_Ack at N+18 with Rd_Data=FF and Timeout=1; a following read answered with 8'h11 reports Timeout=0 and data 11.
- Spurious Rd_DV during IDLE and ACK -> no state change and no Ack; DV arriving on the expiry cycle -> data captured, Timeout=0.
- Assert reset while in WAIT_RD -> all outputs 0 immediately and no Ack; after release, simultaneous requests grant M0 first.

Source files
------------

// File: rtl/bus8_pkg.sv
// Shared types and constants for the 8-bit register bus.
// Used by the two-requester arbiter and its sub-blocks.
package bus8_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_RD,
      ACK
   } bus8_state_t;

   localparam logic       BUS_WRITE       = 1'b1;
   localparam logic       BUS_READ        = 1'b0;
   localparam logic [7:0] RD_TIMEOUT_DATA = 8'hFF;

endpackage

// File: rtl/bus8_rr_arb2.sv
// Two-input round-robin arbiter with a last-grant register.
// Grant is combinational; last-grant advances only on upd.
module bus8_rr_arb2 (
   input  logic       i_Bus_Clk,
   input  logic       i_Bus_Rst_L,
   input  logic [1:0] req,
   input  logic       upd,
   output logic [1:0] gnt
);

   logic last_q;

   always_comb begin
      gnt = 2'b00;
      unique case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = last_q ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

   // Reset to 1 so requester 0 wins the first contention.
   always_ff @(posedge i_Bus_Clk or negedge i_Bus_Rst_L) begin
      if (!i_Bus_Rst_L) begin
         last_q <= 1'b1;
      end else if (upd) begin
         last_q <= gnt[1];
      end
   end

endmodule

// File: rtl/bus8_arbiter_x2.sv
// Round-robin arbiter and sequencer for two masters of the 8-bit
// register bus, with a read watchdog so every request is acked.
import bus8_pkg::*;

module bus8_arbiter_x2 #(
   parameter int ADDR_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  i_Bus_Rst_L,
   input  logic                  i_Bus_Clk,
   input  logic                  i_M0_Req,
   input  logic                  i_M0_Wr_Rd_n,
   input  logic [ADDR_WIDTH-1:0] i_M0_Addr,
   input  logic [7:0]            i_M0_Wr_Data,
   output logic                  o_M0_Ack,
   output logic [7:0]            o_M0_Rd_Data,
   output logic                  o_M0_Timeout,
   input  logic                  i_M1_Req,
   input  logic                  i_M1_Wr_Rd_n,
   input  logic [ADDR_WIDTH-1:0] i_M1_Addr,
   input  logic [7:0]            i_M1_Wr_Data,
   output logic                  o_M1_Ack,
   output logic [7:0]            o_M1_Rd_Data,
   output logic                  o_M1_Timeout,
   output logic                  o_Bus_CS,
   output logic                  o_Bus_Wr_Rd_n,
   output logic [ADDR_WIDTH-1:0] o_Bus_Addr8,
   output logic [7:0]            o_Bus_Wr_Data,
   input  logic [7:0]            i_Bus_Rd_Data,
   input  logic                  i_Bus_Rd_DV,
   output logic                  o_Busy
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   bus8_state_t           state_q, state_d;
   logic                  sel_q, sel_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [1:0]            gnt;
   logic                  arb_upd;
   logic                  cs_d, wr_d, busy_d;
   logic [ADDR_WIDTH-1:0] addr_d;
   logic [7:0]            wd_d;
   logic                  ack0_d, ack1_d, to0_d, to1_d;
   logic [7:0]            rd0_d, rd1_d;
   logic                  done, upd_rd, fin_to;
   logic [7:0]            fin_data;

   bus8_rr_arb2 u_arb (
      .i_Bus_Clk   (i_Bus_Clk),
      .i_Bus_Rst_L (i_Bus_Rst_L),
      .req         ({i_M1_Req, i_M0_Req}),
      .upd         (arb_upd),
      .gnt         (gnt)
   );

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      cnt_d    = cnt_q;
      arb_upd  = 1'b0;
      cs_d     = 1'b0;
      wr_d     = o_Bus_Wr_Rd_n;
      addr_d   = o_Bus_Addr8;
      wd_d     = o_Bus_Wr_Data;
      ack0_d   = 1'b0;
      ack1_d   = 1'b0;
      rd0_d    = o_M0_Rd_Data;
      rd1_d    = o_M1_Rd_Data;
      to0_d    = o_M0_Timeout;
      to1_d    = o_M1_Timeout;
      done     = 1'b0;
      upd_rd   = 1'b0;
      fin_to   = 1'b0;
      fin_data = 8'h00;

      unique case (state_q)
         IDLE: begin
            if (gnt != 2'b00) begin
               arb_upd = 1'b1;
               sel_d   = gnt[1];
               wr_d    = gnt[1] ? i_M1_Wr_Rd_n : i_M0_Wr_Rd_n;
               addr_d  = gnt[1] ? i_M1_Addr    : i_M0_Addr;
               wd_d    = gnt[1] ? i_M1_Wr_Data : i_M0_Wr_Data;
               cs_d    = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            unique case (o_Bus_Wr_Rd_n)
               BUS_WRITE: done = 1'b1;
               BUS_READ: begin
                  cnt_d   = '0;
                  state_d = WAIT_RD;
               end
            endcase
         end
         WAIT_RD: begin
            // Data on the expiry cycle still beats the watchdog.
            if (i_Bus_Rd_DV) begin
               done     = 1'b1;
               upd_rd   = 1'b1;
               fin_data = i_Bus_Rd_Data;
            end else if (cnt_q == CNT_LAST) begin
               done     = 1'b1;
               upd_rd   = 1'b1;
               fin_data = RD_TIMEOUT_DATA;
               fin_to   = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ACK: state_d = IDLE;
      endcase

      if (done) begin
         state_d = ACK;
         if (sel_q) begin
            ack1_d = 1'b1;
            to1_d  = fin_to;
            if (upd_rd) rd1_d = fin_data;
         end else begin
            ack0_d = 1'b1;
            to0_d  = fin_to;
            if (upd_rd) rd0_d = fin_data;
         end
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge i_Bus_Clk or negedge i_Bus_Rst_L) begin
      if (!i_Bus_Rst_L) begin
         state_q       <= IDLE;
         sel_q         <= 1'b0;
         cnt_q         <= '0;
         o_Bus_CS      <= 1'b0;
         o_Bus_Wr_Rd_n <= 1'b0;
         o_Bus_Addr8   <= '0;
         o_Bus_Wr_Data <= 8'h00;
         o_M0_Ack      <= 1'b0;
         o_M1_Ack      <= 1'b0;
         o_M0_Rd_Data  <= 8'h00;
         o_M1_Rd_Data  <= 8'h00;
         o_M0_Timeout  <= 1'b0;
         o_M1_Timeout  <= 1'b0;
         o_Busy        <= 1'b0;
      end else begin
         state_q       <= state_d;
         sel_q         <= sel_d;
         cnt_q         <= cnt_d;
         o_Bus_CS      <= cs_d;
         o_Bus_Wr_Rd_n <= wr_d;
         o_Bus_Addr8   <= addr_d;
         o_Bus_Wr_Data <= wd_d;
         o_M0_Ack      <= ack0_d;
         o_M1_Ack      <= ack1_d;
         o_M0_Rd_Data  <= rd0_d;
         o_M1_Rd_Data  <= rd1_d;
         o_M0_Timeout  <= to0_d;
         o_M1_Timeout  <= to1_d;
         o_Busy        <= busy_d;
      end
   end

endmodule

// File: tb/tb_bus8_arbiter_x2.sv
// Bench for bus8_arbiter_x2: random masters and slave against a
// transaction-timeline model of grants, strobes and acks.
module tb_bus8_arbiter_x2;

   localparam int T = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       m0_req = 0, m0_wr = 0, m1_req = 0, m1_wr = 0;
   logic [7:0] m0_addr = 0, m0_wd = 0, m1_addr = 0, m1_wd = 0;
   logic       m0_ack, m0_to, m1_ack, m1_to;
   logic [7:0] m0_rd, m1_rd;
   logic       cs, bwr, busy;
   logic [7:0] baddr, bwd;
   logic [7:0] rdat = 0;
   logic       rdv = 0;

   always #5 clk = ~clk;

   bus8_arbiter_x2 #(.ADDR_WIDTH(8), .TIMEOUT_CYCLES(T)) dut (
      .i_Bus_Rst_L   (rst_n),
      .i_Bus_Clk     (clk),
      .i_M0_Req      (m0_req),
      .i_M0_Wr_Rd_n  (m0_wr),
      .i_M0_Addr     (m0_addr),
      .i_M0_Wr_Data  (m0_wd),
      .o_M0_Ack      (m0_ack),
      .o_M0_Rd_Data  (m0_rd),
      .o_M0_Timeout  (m0_to),
      .i_M1_Req      (m1_req),
      .i_M1_Wr_Rd_n  (m1_wr),
      .i_M1_Addr     (m1_addr),
      .i_M1_Wr_Data  (m1_wd),
      .o_M1_Ack      (m1_ack),
      .o_M1_Rd_Data  (m1_rd),
      .o_M1_Timeout  (m1_to),
      .o_Bus_CS      (cs),
      .o_Bus_Wr_Rd_n (bwr),
      .o_Bus_Addr8   (baddr),
      .o_Bus_Wr_Data (bwd),
      .i_Bus_Rd_Data (rdat),
      .i_Bus_Rd_DV   (rdv),
      .o_Busy        (busy)
   );

   typedef struct {
      logic       wr;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [7:0] rdata;
      int         dly;
   } txn_t;

   txn_t q [2][$];
   bit   active [2];
   bit   ack_prev [2];
   int   start_pct, b2b_pct, spur_pct;

   int n_cmp = 0, n_bad = 0;

   int         cyc = 0, next_sample, last, who;
   int         exp_cs, exp_ack, dv_cyc, wait_lo, wait_hi;
   logic       exp_wr, pend_to;
   logic [7:0] exp_addr, exp_wd, pend_rd, dv_data;
   logic [7:0] rd_exp [2];
   logic       to_exp [2];

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         if (n_bad <= 40)
            $display("FAIL %s @cyc %0d: got %0h want %0h",
                     tag, cyc, got, exp);
      end
   endtask

   function automatic txn_t mk(logic wr, logic [7:0] a,
                               logic [7:0] d, int dly);
      txn_t t;
      t.wr = wr; t.addr = a; t.wdata = d; t.rdata = d; t.dly = dly;
      return t;
   endfunction

   function automatic txn_t rnd();
      txn_t t;
      t.wr    = 1'($urandom_range(0, 1));
      t.addr  = 8'($urandom);
      t.wdata = 8'($urandom);
      t.rdata = 8'($urandom);
      t.dly   = $urandom_range(0, T + 2);
      return t;
   endfunction

   task automatic model_reset();
      last = 1; next_sample = 0; who = 0;
      exp_cs = -1; exp_ack = -1; dv_cyc = -1;
      wait_lo = 1; wait_hi = 0;
      exp_wr = 0; exp_addr = 0; exp_wd = 0;
      pend_rd = 0; pend_to = 0; dv_data = 0;
      for (int x = 0; x < 2; x++) begin
         rd_exp[x] = 0; to_exp[x] = 0;
         active[x] = 0; ack_prev[x] = 0;
         q[x].delete();
      end
   endtask

   task automatic chk_zero();
      chk("rst_cs", cs, 0);
      chk("rst_busy", busy, 0);
      chk("rst_bwr", bwr, 0);
      chk("rst_addr", baddr, 0);
      chk("rst_wd", bwd, 0);
      chk("rst_ack", {m1_ack, m0_ack}, 0);
      chk("rst_rd", {m1_rd, m0_rd}, 0);
      chk("rst_to", {m1_to, m0_to}, 0);
   endtask

   task automatic step();
      bit a [2];
      txn_t t;
      @(posedge clk);
      #1;
      cyc++;
      a[0] = (cyc == exp_ack) && (who == 0);
      a[1] = (cyc == exp_ack) && (who == 1);
      if (cyc == exp_ack) begin
         rd_exp[who] = pend_rd;
         to_exp[who] = pend_to;
      end
      chk("cs", cs, cyc == exp_cs);
      chk("bus_wr", bwr, exp_wr);
      chk("bus_addr", baddr, exp_addr);
      chk("bus_wd", bwd, exp_wd);
      chk("busy", busy, cyc < next_sample);
      chk("ack0", m0_ack, a[0]);
      chk("ack1", m1_ack, a[1]);
      chk("rd0", m0_rd, rd_exp[0]);
      chk("rd1", m1_rd, rd_exp[1]);
      chk("to0", m0_to, to_exp[0]);
      chk("to1", m1_to, to_exp[1]);

      // Masters: registered reaction to the ack of the previous cycle.
      for (int x = 0; x < 2; x++) begin
         if (ack_prev[x]) begin
            q[x].delete(0);
            active[x] = (q[x].size() > 0) &&
                        ($urandom_range(0, 99) < b2b_pct);
         end else if (!active[x] && q[x].size() > 0 &&
                      $urandom_range(0, 99) < start_pct) begin
            active[x] = 1;
         end
         ack_prev[x] = a[x];
      end
      m0_req = active[0];
      m1_req = active[1];
      if (active[0]) begin
         m0_wr = q[0][0].wr; m0_addr = q[0][0].addr; m0_wd = q[0][0].wdata;
      end
      if (active[1]) begin
         m1_wr = q[1][0].wr; m1_addr = q[1][0].addr; m1_wd = q[1][0].wdata;
      end

      // Slave: scheduled answer, or noise outside the read window.
      rdat = 8'($urandom);
      if (cyc == dv_cyc) begin
         rdv = 1; rdat = dv_data;
      end else if (!(cyc >= wait_lo && cyc <= wait_hi) &&
                   $urandom_range(0, 99) < spur_pct) begin
         rdv = 1;
      end else begin
         rdv = 0;
      end

      // Timeline model of the arbiter.
      if (cyc >= next_sample && (active[0] || active[1])) begin
         if (active[0] && active[1]) who = 1 - last;
         else who = active[1] ? 1 : 0;
         last = who;
         t = q[who][0];
         exp_cs = cyc + 1;
         exp_wr = t.wr; exp_addr = t.addr; exp_wd = t.wdata;
         if (t.wr) begin
            exp_ack = cyc + 2;
            pend_rd = rd_exp[who]; pend_to = 0;
            dv_cyc = -1; wait_lo = 1; wait_hi = 0;
         end else begin
            wait_lo = cyc + 2;
            pend_to = 0;
            if (t.dly < T) begin
               dv_cyc = cyc + 2 + t.dly;
               dv_data = t.rdata;
               exp_ack = cyc + 3 + t.dly;
               pend_rd = t.rdata;
            end else begin
               dv_cyc = -1;
               exp_ack = cyc + 2 + T;
               pend_rd = 8'hFF;
               pend_to = 1;
            end
            wait_hi = exp_ack - 1;
         end
         next_sample = exp_ack + 1;
      end
   endtask

   task automatic run_idle(int budget);
      int n = 0;
      while (!(q[0].size() == 0 && q[1].size() == 0 &&
               !active[0] && !active[1] && cyc >= next_sample) &&
             n < budget) begin
         step();
         n++;
      end
      if (n >= budget) chk("idle_wait", 0, 1);
   endtask

   initial begin
      model_reset();
      start_pct = 100; b2b_pct = 0; spur_pct = 50;
      repeat (3) @(posedge clk);
      #1;
      chk_zero();
      @(negedge clk);
      rst_n = 1;

      q[0].push_back(mk(1, 8'h01, 8'hA5, 0));
      run_idle(50);
      q[1].push_back(mk(0, 8'h00, 8'h3C, 0));
      run_idle(50);

      b2b_pct = 100;
      for (int i = 0; i < 3; i++) begin
         q[0].push_back(mk(i[0], 8'(8'h10 + i), 8'(8'h20 + i), 1));
         q[1].push_back(mk(~i[0], 8'(8'h30 + i), 8'(8'h40 + i), 2));
      end
      run_idle(200);

      b2b_pct = 0;
      q[0].push_back(mk(0, 8'h05, 8'h00, T + 3));
      q[0].push_back(mk(0, 8'h06, 8'h11, 0));
      run_idle(100);
      q[1].push_back(mk(0, 8'h07, 8'h5A, T - 1));
      run_idle(100);

      start_pct = 30; b2b_pct = 50; spur_pct = 25;
      for (int i = 0; i < 60; i++) begin
         q[0].push_back(rnd());
         q[1].push_back(rnd());
      end
      run_idle(6000);

      start_pct = 100; b2b_pct = 0;
      q[0].push_back(mk(0, 8'h99, 8'h00, T + 5));
      begin
         int n = 0;
         while (!(exp_cs > 0 && cyc == exp_cs + 4) && n < 50) begin
            step();
            n++;
         end
         if (n >= 50) chk("wait_rd_reach", 0, 1);
      end
      #3;
      rst_n = 0;
      #1;
      chk_zero();
      model_reset();
      m0_req = 0; m1_req = 0; rdv = 0;
      repeat (2) @(posedge clk);
      #1;
      chk_zero();
      @(negedge clk);
      rst_n = 1;
      start_pct = 100;
      q[0].push_back(mk(1, 8'hC0, 8'h01, 0));
      q[1].push_back(mk(1, 8'hC1, 8'h02, 0));
      run_idle(100);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
